dmem_responder: RTL and testbench

- Memory-side responder that services load/store requests issued by the pipelined core's MEM stage.
- Holds word-organised data storage. Inserts a fixed number of wait states per access and returns a one-cycle ready pulse.
- While a request is outstanding, the core holds its pipeline registers (en_reg low) until ready is seen.
- Replaces the zero-latency data memory model so the core's stall path can be exercised.

---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the core's memory-side responders:
// FSM encoding, index sizing and fault codes.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE     = 2'd0;
    localparam fault_t FAULT_MISALIGN = 2'd1;
    localparam fault_t FAULT_RANGE    = 2'd2;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

    // iw is the word-index width; anything above it is out of range
    function automatic fault_t fault_code(
        input logic [31:0] addr,
        input int          iw
    );
        if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
        if ((addr >> (iw + 2)) != 32'd0) return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the core's MEM stage
// (master) and a data-memory responder (slave).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        ready;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, byte_en,
        input  ready, rdata, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, byte_en,
        output ready, rdata, busy, err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-lane synchronous write,
// asynchronous read. Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int IW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed wait states; busy stalls
// the core until the one-cycle ready pulse.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int         IW        = idx_width(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        cur_we;
    logic [31:0] cur_addr;
    fault_t      fault;
    logic [31:0] mem_rd;
    logic        mem_we;

    // In IDLE the live bus is the access about to be accepted
    assign cur_we   = (state_q == ST_IDLE) ? bus.we : we_q;
    assign cur_addr = (state_q == ST_IDLE) ? bus.addr : addr_q;
    assign fault    = fault_code(cur_addr, IW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    be_d    = bus.byte_en;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response flops load on the edge that enters RESP
    always_comb begin
        ready_d = (state_d == ST_RESP);
        err_d   = ready_d && (fault != FAULT_NONE);
        rdata_d = rdata_q;
        if (ready_d && !cur_we) begin
            rdata_d = (fault == FAULT_NONE) ? mem_rd : 32'd0;
        end
        mem_we = (state_q == ST_RESP) && we_q && (fault == FAULT_NONE);
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != ST_IDLE);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (cur_addr[IW+1:2]),
        .wdata(wdata_q),
        .be   (be_q),
        .rdata(mem_rd)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// checked every cycle against a timeline/memory model.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_responder_if b2();
    dmem_responder_if b0();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];

    assign b2.req = req[0];
    assign b2.we = we[0];
    assign b2.addr = addr[0];
    assign b2.wdata = wdata[0];
    assign b2.byte_en = be[0];
    assign b0.req = req[1];
    assign b0.we = we[1];
    assign b0.addr = addr[1];
    assign b0.wdata = wdata[1];
    assign b0.byte_en = be[1];

    logic        o_ready [2];
    logic        o_busy  [2];
    logic        o_err   [2];
    logic [31:0] o_rdata [2];

    assign o_ready[0] = b2.ready;
    assign o_busy[0]  = b2.busy;
    assign o_err[0]   = b2.err;
    assign o_rdata[0] = b2.rdata;
    assign o_ready[1] = b0.ready;
    assign o_busy[1]  = b0.busy;
    assign o_err[1]   = b0.err;
    assign o_rdata[1] = b0.rdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Model: one access per window; accepted at edge acc,
    // busy for cycles acc..acc+W, ready in acc+W, write at acc+W+1.
    int          cyc = 0;
    bit          pend    [2];
    int          acc     [2];
    int          next_ok [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [3:0]  m_be    [2];
    bit          m_fault [2];
    logic [31:0] m_load  [2];
    logic [31:0] mm      [2][256];
    logic [31:0] exp_rd  [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                pend[d] = 1'b0;
                next_ok[d] = 0;
            end
        end else if (clk) begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && cyc == acc[d] + wc(d) + 1) begin
                    if (m_we[d] && !m_fault[d]) begin
                        for (int i = 0; i < 4; i++) begin
                            if (m_be[d][i]) begin
                                mm[d][m_addr[d] / 4][8*i +: 8] = m_wd[d][8*i +: 8];
                            end
                        end
                    end
                    pend[d] = 1'b0;
                end
                if (!pend[d] && cyc >= next_ok[d] && req[d] === 1'b1) begin
                    pend[d] = 1'b1;
                    acc[d] = cyc;
                    next_ok[d] = cyc + wc(d) + 2;
                    m_we[d] = we[d];
                    m_addr[d] = addr[d];
                    m_wd[d] = wdata[d];
                    m_be[d] = be[d];
                    m_fault[d] = (addr[d] % 4 != 0) || (addr[d] / 4 >= 256);
                    m_load[d] = m_fault[d] ? 32'd0 : mm[d][addr[d] / 4];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit e_busy;
            bit e_ready;
            e_busy = pend[d] && cyc >= acc[d] && cyc <= acc[d] + wc(d);
            e_ready = pend[d] && cyc == acc[d] + wc(d);
            if (!rst) exp_rd[d] = 32'd0;
            else if (e_ready && !m_we[d]) exp_rd[d] = m_load[d];
            chk($sformatf("d%0d_busy@%0d", d, cyc), 32'(o_busy[d]), 32'(e_busy));
            chk($sformatf("d%0d_ready@%0d", d, cyc), 32'(o_ready[d]), 32'(e_ready));
            chk($sformatf("d%0d_err@%0d", d, cyc), 32'(o_err[d]),
                32'(e_ready && m_fault[d]));
            chk($sformatf("d%0d_rdata@%0d", d, cyc), o_rdata[d], exp_rd[d]);
        end
    end

    // Starts #1 after a posedge with the DUT idle; returns likewise.
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] bytes,
                          input bit scramble,
                          output logic [31:0] rd, output bit e,
                          output int lat, output int bcnt);
        bit got;
        req[d] = 1'b1;
        we[d] = w;
        addr[d] = a;
        wdata[d] = wd;
        be[d] = bytes;
        lat = 0;
        bcnt = 0;
        rd = '0;
        e = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (o_busy[d]) bcnt++;
            if (o_ready[d]) begin
                rd = o_rdata[d];
                e = o_err[d];
                got = 1'b1;
            end
            if (scramble && lat == 2) begin
                addr[d] = ~a;
                wdata[d] = ~wd;
                we[d] = ~w;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout d%0d addr %h: got no ready want ready", d, a);
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        we[d] = 1'b0;
        addr[d] = '0;
        wdata[d] = '0;
        be[d] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit e;
        int lat;
        int bc;
        int n;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0;
            we[d] = 1'b0;
            addr[d] = '0;
            wdata[d] = '0;
            be[d] = '0;
        end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(o_ready[0]), 32'd0);
        chk("rst_busy", 32'(o_busy[0]), 32'd0);
        chk("rst_err", 32'(o_err[0]), 32'd0);
        chk("rst_rdata", o_rdata[0], 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        access(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, e, lat, bc);
        access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat, bc);
        chk("st_latency", 32'(lat), 32'd4);
        chk("st_busy_cycles", 32'(bc), 32'd3);
        chk("st_err", 32'(e), 32'd0);
        access(0, 0, 32'h10, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("ld_10", rd, 32'hDEADBEEF);

        access(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd, e, lat, bc);
        access(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, rd, e, lat, bc);
        access(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat, bc);
        chk("ld_lanes", rd, 32'h11BB33DD);

        access(0, 0, 32'h22, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("misalign_err", 32'(e), 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        access(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, e, lat, bc);
        chk("range_err", 32'(e), 32'd1);
        access(0, 0, 32'h0, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("ld_0_unchanged", rd, 32'h0BADF00D);
        chk("ld_0_err", 32'(e), 32'd0);

        access(0, 1, 32'h10, 32'h0, 4'h0, 0, rd, e, lat, bc);
        access(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat, bc);
        chk("be0_store_noop", rd, 32'hDEADBEEF);

        access(0, 1, 32'h30, 32'h30303030, 4'hF, 0, rd, e, lat, bc);
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr[0] = 32'h30;
        wdata[0] = 32'hFFFFFFFF;
        be[0] = 4'hF;
        n = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_ready[0]) n++;
        end
        req[0] = 1'b0;
        we[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_mid_no_ready", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        access(0, 0, 32'h30, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("ld_30_after_rst", rd, 32'h30303030);

        access(1, 1, 32'h40, 32'h12345678, 4'hF, 0, rd, e, lat, bc);
        chk("w0_latency", 32'(lat), 32'd2);
        chk("w0_busy_cycles", 32'(bc), 32'd1);
        req[1] = 1'b1;
        we[1] = 1'b1;
        addr[1] = 32'h44;
        wdata[1] = 32'hCAFEF00D;
        be[1] = 4'hF;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_ready[1]) n++;
        end
        @(posedge clk);
        #1 req[1] = 1'b0;
        chk("b2b_pulses", 32'(n), 32'd4);
        access(1, 0, 32'h44, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("w0_ld_44", rd, 32'hCAFEF00D);
        access(1, 0, 32'h40, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("w0_ld_40", rd, 32'h12345678);
        access(1, 0, 32'h41, 32'h0, 4'hF, 0, rd, e, lat, bc);
        chk("w0_misalign_err", 32'(e), 32'd1);
        chk("w0_misalign_rdata", rd, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
